// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA timing decoder: recovers pixel coordinates from hsync/vsync and validates lock.
// Optional VGA_RX_MEASURE_EN adds measured line_len/frame_lines outputs.
module vga_sync_decoder #(
  parameter int H_DISPLAY = 640,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int H_TOTAL   = 800,
  parameter int V_DISPLAY = 480,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_TOTAL   = 525
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err
`ifdef VGA_RX_MEASURE_EN
  ,
  output logic [9:0]  line_len,
  output logic [9:0]  frame_lines
`endif
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BACK + H_DISPLAY);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BACK + V_DISPLAY);
  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t      state, state_next;
  logic        hs_prev, vs_prev;
  logic [11:0] rgb_q;
  logic [9:0]  hcnt, vcnt;
  logic        vpend;
  logic        first_fall, first_fall_next;
  logic        frame_bad, frame_bad_next;
  logic        armed, armed_next;
  logic [1:0]  good_cnt, good_cnt_next;
  logic        err_set;
  logic        tick_d, clr_d;

  logic        h_fall, v_fall, v_clear, line_bad, vcheck_bad;
  logic        h_act, v_act;

  // Edges compare the stored sample against the one being captured this tick.
  assign h_fall     = p_tick & hs_prev & ~hsync;
  assign v_fall     = p_tick & vs_prev & ~vsync;
  assign v_clear    = h_fall & (vpend | v_fall);
  assign line_bad   = h_fall & ~first_fall & (hcnt != H_LAST);
  assign vcheck_bad = v_clear & (vcnt != V_LAST);

  assign h_act  = (hcnt >= H_START) && (hcnt < H_END);
  assign v_act  = (vcnt >= V_START) && (vcnt < V_END);
  assign locked = (state == LOCKED);

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state      <= SEARCH;
      good_cnt   <= 2'd0;
      frame_bad  <= 1'b0;
      armed      <= 1'b0;
      first_fall <= 1'b1;
      timing_err <= 1'b0;
    end else begin
      state      <= state_next;
      good_cnt   <= good_cnt_next;
      frame_bad  <= frame_bad_next;
      armed      <= armed_next;
      first_fall <= first_fall_next;
      timing_err <= timing_err | err_set;
    end
  end

  // armed marks that the frame boundary opening the current ALIGN frame has been seen,
  // so a vsync that falls mid-line does not get its first clear judged as a frame end.
  always_comb begin
    state_next     = state;
    good_cnt_next  = good_cnt;
    frame_bad_next = frame_bad;
    armed_next     = armed;
    err_set        = 1'b0;
    case (state)
      SEARCH: begin
        good_cnt_next  = 2'd0;
        frame_bad_next = 1'b0;
        armed_next     = 1'b0;
        if (v_fall) begin
          state_next = ALIGN;
          armed_next = v_clear;
        end
      end
      ALIGN: begin
        if (line_bad) frame_bad_next = 1'b1;
        if (v_clear) begin
          frame_bad_next = 1'b0;
          if (!armed) begin
            armed_next = 1'b1;
          end else if (frame_bad | line_bad | vcheck_bad) begin
            state_next    = SEARCH;
            good_cnt_next = 2'd0;
          end else if (good_cnt == 2'd1) begin
            state_next    = LOCKED;
            good_cnt_next = 2'd2;
          end else begin
            good_cnt_next = good_cnt + 2'd1;
          end
        end
      end
      LOCKED: begin
        if (line_bad | vcheck_bad) begin
          state_next    = SEARCH;
          good_cnt_next = 2'd0;
          err_set       = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase

    first_fall_next = first_fall;
    if (h_fall) first_fall_next = 1'b0;
    if (state != SEARCH && state_next == SEARCH) first_fall_next = 1'b1;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      rgb_q   <= 12'd0;
      hcnt    <= 10'd0;
      vcnt    <= 10'd0;
      vpend   <= 1'b0;
      tick_d  <= 1'b0;
      clr_d   <= 1'b0;
    end else begin
      tick_d <= p_tick;
      clr_d  <= v_clear;
      if (p_tick) begin
        hs_prev <= hsync;
        vs_prev <= vsync;
        rgb_q   <= rgb;
        if (h_fall) begin
          hcnt <= 10'd0;
        end else if (hcnt != CNT_MAX) begin
          hcnt <= hcnt + 10'd1;
        end
        if (v_clear) begin
          vcnt  <= 10'd0;
          vpend <= 1'b0;
        end else begin
          if (h_fall && vcnt != CNT_MAX) vcnt <= vcnt + 10'd1;
          if (v_fall) vpend <= 1'b1;
        end
      end
    end
  end

  // Counters and state already reflect the tick that sampled this pixel.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      pix_valid   <= tick_d & locked & h_act & v_act;
      frame_start <= clr_d & locked;
      if (tick_d && h_act && v_act) begin
        pix_x   <= hcnt - H_START;
        pix_y   <= vcnt - V_START;
        pix_rgb <= rgb_q;
      end
    end
  end

`ifdef VGA_RX_MEASURE_EN
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      line_len    <= 10'd0;
      frame_lines <= 10'd0;
    end else begin
      if (h_fall)  line_len    <= hcnt + 10'd1;
      if (v_clear) frame_lines <= vcnt + 10'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - frame-table bench for vga_sync_decoder on a reduced 14x8 timing.
module tb_vga_sync_decoder;
  localparam int HD = 8, HS = 2, HB = 2, HT = 14;
  localparam int VD = 4, VS = 1, VB = 1, VT = 8;
  localparam int NPIX = HD * VD;

  logic        clk = 1'b0;
  logic        reset, p_tick, hsync, vsync;
  logic [11:0] rgb;
  logic        pix_valid, frame_start, locked, timing_err;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
`ifdef VGA_RX_MEASURE_EN
  logic [9:0]  line_len, frame_lines;
`endif

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb    (pix_rgb),
    .frame_start(frame_start),
    .locked     (locked),
    .timing_err (timing_err)
`ifdef VGA_RX_MEASURE_EN
    ,
    .line_len   (line_len),
    .frame_lines(frame_lines)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cur_gh, cur_gv;
  logic [11:0] cur_rgb;
  int n_valid, n_fs, n_red, coord_bad;
  int first_x, first_y, last_x, last_y;
  int lk_first;

  typedef struct {
    string name;
    int    short_line;
    bit    red;
    int    rst_line;
    int    idle;
    int    exp_lk_first;
    int    exp_valid;
    int    exp_fs;
    int    exp_red;
    int    exp_lk_end;
    int    exp_err_end;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pix_valid) begin
      if (n_valid == 0) begin
        first_x = int'(pix_x);
        first_y = int'(pix_y);
      end
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      n_valid++;
      if (int'(pix_x) != cur_gh - HS - HB || int'(pix_y) != cur_gv - VS - VB || pix_rgb != cur_rgb)
        coord_bad++;
      if (pix_x == 10'd3 && pix_y == 10'd1 && pix_rgb == 12'hF00) n_red++;
    end
    if (frame_start) n_fs++;
  end

  task automatic send_pixel(input logic hs, input logic vs, input logic [11:0] c, input int gh, input int gv);
    @(negedge clk);
    cur_gh = gh; cur_gv = gv; cur_rgb = c;
    hsync = hs; vsync = vs; rgb = c; p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_cleared(input string name);
    check({name, "_ctl"}, int'({pix_valid, frame_start, locked, timing_err}), 0);
    check({name, "_xy"}, int'(pix_x) + int'(pix_y), 0);
    check({name, "_rgb"}, int'(pix_rgb), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_cleared("midframe_reset");
  endtask

  task automatic run_frame(input vec_t v);
    int len;
    logic [11:0] c;
    for (int i = 0; i < v.idle; i++) send_pixel(1'b1, 1'b1, 12'h000, 9999, 9999);
    for (int gv = 0; gv < VT; gv++) begin
      len = (gv == v.short_line) ? HT - 1 : HT;
      for (int gh = 0; gh < len; gh++) begin
        if (gv == v.rst_line && gh == 6) pulse_reset();
        c = (v.red && gh == HS + HB + 3 && gv == VS + VB + 1) ? 12'hF00 : 12'(gv * 16 + gh);
        send_pixel(gh >= HS, gv >= VS, c, gh, gv);
        if (gh == 0 && gv == 0) lk_first = int'(locked);
        if (v.short_line >= 0 && gv == v.short_line && gh == len - 1)
          check("short_locked_before", int'(locked), 1);
        if (v.short_line >= 0 && gv == v.short_line + 1 && gh == 0) begin
          check("short_locked_at_fall", int'(locked), 0);
          check("short_err_at_fall", int'(timing_err), 1);
`ifdef VGA_RX_MEASURE_EN
          check("short_line_len", int'(line_len), HT - 1);
`endif
        end
      end
    end
  endtask

  initial begin
    //               name           short red rst  idle  lk0 valid fs red lkE errE
    vecs[0]  = '{"f0_search",      -1, 0, -1,    0,  0,    0, 0, 0, 0, 0};
    vecs[1]  = '{"f1_align",       -1, 0, -1,    0,  0,    0, 0, 0, 0, 0};
    vecs[2]  = '{"f2_lock",        -1, 0, -1,    0,  1, NPIX, 1, 0, 1, 0};
    vecs[3]  = '{"f3_red",         -1, 1, -1,    0,  1, NPIX, 1, 1, 1, 0};
    vecs[4]  = '{"f4_short",        5, 0, -1,    0,  1, NPIX, 1, 0, 0, 1};
    vecs[5]  = '{"f5_search",      -1, 0, -1,    0,  0,    0, 0, 0, 0, 1};
    vecs[6]  = '{"f6_align",       -1, 0, -1,    0,  0,    0, 0, 0, 0, 1};
    vecs[7]  = '{"f7_relock",      -1, 0, -1,    0,  1, NPIX, 1, 0, 1, 1};
    vecs[8]  = '{"f8_reset",       -1, 0,  3,    0,  1,   10, 1, 0, 0, 0};
    vecs[9]  = '{"f9_search",      -1, 0, -1,    0,  0,    0, 0, 0, 0, 0};
    vecs[10] = '{"f10_align",      -1, 0, -1,    0,  0,    0, 0, 0, 0, 0};
    vecs[11] = '{"f11_relock",     -1, 0, -1,    0,  1, NPIX, 1, 0, 1, 0};
    vecs[12] = '{"f12_nohsync",    -1, 0, -1, 1100,  0,    0, 0, 0, 0, 1};

    reset = 1'b1; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = 12'h000;
    cur_gh = 9999; cur_gv = 9999; cur_rgb = 12'h000;
    n_valid = 0; n_fs = 0; n_red = 0; coord_bad = 0;
    repeat (3) @(negedge clk);
    check_cleared("reset_state");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      n_valid = 0; n_fs = 0; n_red = 0; coord_bad = 0;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1;
      lk_first = -1;
      run_frame(vecs[i]);
      check({vecs[i].name, "_locked_first"}, lk_first, vecs[i].exp_lk_first);
      check({vecs[i].name, "_valid_count"}, n_valid, vecs[i].exp_valid);
      check({vecs[i].name, "_frame_start"}, n_fs, vecs[i].exp_fs);
      check({vecs[i].name, "_red_pixel"}, n_red, vecs[i].exp_red);
      check({vecs[i].name, "_pixel_data"}, coord_bad, 0);
      check({vecs[i].name, "_locked_end"}, int'(locked), vecs[i].exp_lk_end);
      check({vecs[i].name, "_err_end"}, int'(timing_err), vecs[i].exp_err_end);
      if (vecs[i].exp_valid == NPIX) begin
        check({vecs[i].name, "_first_xy"}, first_x * 1024 + first_y, 0);
        check({vecs[i].name, "_last_xy"}, last_x * 1024 + last_y, (HD - 1) * 1024 + (VD - 1));
      end
`ifdef VGA_RX_MEASURE_EN
      if (i == 11) begin
        check("measure_line_len", int'(line_len), HT);
        check("measure_frame_lines", int'(frame_lines), VT);
      end
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- H_DISPLAY, 640, active pixels per line.
- H_SYNC, 96, hsync pulse width in pixels.
- H_BACK, 48, pixels from hsync end to first active pixel.
- H_TOTAL, 800, pixels per line.
- V_DISPLAY, 480, active lines per frame.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, lines from vsync end to first active line.
- V_TOTAL, 525, lines per frame.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_100MHz, in, 1, the only clock.
- reset, in, 1, synchronous, active-high.
- p_tick, in, 1, pixel-rate enable, one clk in four.
- hsync, in, 1, active-low horizontal sync.
- vsync, in, 1, active-low vertical sync.
- rgb, in, 12, pixel colour.
- pix_valid, out, 1, one-clk strobe marking an active pixel.
- pix_x, out, 10, pixel column, 0..H_DISPLAY-1.
- pix_y, out, 10, pixel row, 0..V_DISPLAY-1.
- pix_rgb, out, 12, captured colour.
- frame_start, out, 1, one-clk pulse at each locked frame boundary.
- locked, out, 1, timing validated.
- timing_err, out, 1, sticky loss-of-lock flag.

Function
REQ-003 hsync, vsync and rgb SHALL be registered only on clk edges where p_tick=1; all logic SHALL advance only on p_tick cycles.
REQ-004 An hsync fall SHALL be detected when the previous sample is 1 and the current sample is 0; a vsync fall SHALL be detected the same way.
REQ-005 Horizontal counter hcnt (10 bit) behaviour:
- Cleared to 0 on an hsync fall.
- Otherwise incremented, saturating at 1023.
REQ-006 On each hsync fall, the line SHALL be flagged bad if hcnt != H_TOTAL-1. The first fall after SEARCH is exempt.
REQ-007 A vsync fall SHALL set vpend.
REQ-008 Vertical counter vcnt behaviour on each hsync fall:
- If vpend=1: check vcnt == V_TOTAL-1, then clear vcnt to 0 and clear vpend.
- Otherwise: increment vcnt, saturating at 1023.
REQ-009 When vsync and hsync fall on the same tick, that hsync fall SHALL perform the vcnt clear.
REQ-010 Active region:
- hcnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISPLAY).
- vcnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISPLAY).
- pix_x = hcnt-(H_SYNC+H_BACK); pix_y = vcnt-(V_SYNC+V_BACK).
REQ-011 pix_valid, pix_x, pix_y and pix_rgb SHALL be registered, appearing 1 clk after the p_tick cycle that samples the pixel. pix_valid SHALL be high for exactly 1 clk and only when locked=1.
REQ-012 The FSM SHALL have states SEARCH, ALIGN and LOCKED.
REQ-013 FSM transitions:
- SEARCH -> ALIGN on a vsync fall.
- ALIGN: at each vcnt clear, a good frame (no bad line, vcnt check passed) increments good_cnt; at good_cnt=2 go to LOCKED; any bad frame returns to SEARCH with good_cnt=0.
- LOCKED -> SEARCH on any bad line or failed vcnt check, setting timing_err.
REQ-014 locked SHALL be 1 only in LOCKED. frame_start SHALL pulse for 1 clk at each vcnt clear while in LOCKED, aligned with the REQ-011 outputs.
REQ-015 timing_err SHALL remain set until reset.
REQ-016 If hsync is absent, hcnt SHALL saturate with no wrap and no pix_valid, and the next hsync fall SHALL be judged bad.

Reset
REQ-017 While reset=1, every output SHALL be 0 at the next clk edge.
REQ-018 Reset SHALL put the FSM in SEARCH and clear hcnt, vcnt, vpend, good_cnt, timing_err and the sampled sync registers. Sampled syncs reset to 1 so that no edge is detected at release.
REQ-019 A reset mid-frame SHALL require a fresh vsync fall followed by two good frames before locked=1.

Configuration
REQ-020 With VGA_RX_MEASURE_EN defined, the block SHALL add two outputs:
- line_len [9:0]: hcnt+1 latched at each hsync fall.
- frame_lines [9:0]: vcnt+1 latched at each vcnt clear.
Both SHALL reset to 0 and update in all FSM states.
REQ-021 Without VGA_RX_MEASURE_EN, these ports and their registers SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-022 Standard 640x480 timing from a reference generator, 3 frames:
- locked rises at the start of frame 3.
- Thereafter 307200 pix_valid per frame.
- First pix_valid has pix_x=0, pix_y=0.
- Last pix_valid has pix_x=639, pix_y=479.
REQ-023 rgb=12'hF00 at column 10, row 5 of a locked frame -> pix_rgb=12'hF00 with pix_x=10, pix_y=5, 1 clk after the sampling tick.
REQ-024 While locked, one line shortened to 799 pixels -> locked=0 and timing_err=1 at that hsync fall; no pix_valid until two good frames follow.
REQ-025 vsync and hsync falling on the same tick -> vcnt=0 on that tick and frame_start pulses once.
REQ-026 reset asserted for 1 clk mid-frame while locked -> all outputs 0 next clk and locked stays 0 for two full frames. With VGA_RX_MEASURE_EN: line_len=800 and frame_lines=525 after lock.
